// File: rtl/ospfb_fft_sequencer.sv
// Run-time sequencer for the OSPFB FFT stage: FFT reset, config load, frame watch, resync/fault.
// Define OSPFB_FFT_SEQ_STATS_EN to build live overflow/halt/resync statistics counters.
module ospfb_fft_sequencer #(
    parameter int unsigned FFT_CONF_WID   = 16,
    parameter int unsigned FFT_RST_CYCLES = 2,
    parameter int unsigned FRAME_TIMEOUT  = 4096,
    parameter int unsigned MAX_RETRY      = 3,
    parameter int unsigned CNT_WID        = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [FFT_CONF_WID-2:0] cfg_sched,
    input  logic                    cfg_fwd,
    input  logic                    cfg_update,
    output logic [FFT_CONF_WID-1:0] m_axis_fft_config_tdata,
    output logic                    m_axis_fft_config_tvalid,
    input  logic                    m_axis_fft_config_tready,
    output logic                    fft_aresetn,
    output logic                    ospfb_en,
    input  logic                    event_frame_started,
    input  logic                    event_tlast_unexpected,
    input  logic                    event_tlast_missing,
    input  logic                    event_fft_overflow,
    input  logic                    event_data_in_channel_halt,
    output logic [2:0]              state,
    output logic                    fault,
    output logic [CNT_WID-1:0]      overflow_cnt,
    output logic [CNT_WID-1:0]      halt_cnt,
    output logic [CNT_WID-1:0]      resync_cnt
);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] FFT_RST    = 3'd1;
    localparam logic [2:0] CONFIG     = 3'd2;
    localparam logic [2:0] WAIT_FRAME = 3'd3;
    localparam logic [2:0] RUN        = 3'd4;
    localparam logic [2:0] RESYNC     = 3'd5;
    localparam logic [2:0] FAULT      = 3'd6;

    localparam int unsigned RST_W = $clog2(FFT_RST_CYCLES + 1);
    localparam int unsigned TMR_W = $clog2(FRAME_TIMEOUT + 1);
    localparam int unsigned RTY_W = $clog2(MAX_RETRY + 1);

    localparam logic [RST_W-1:0] RST_LAST = RST_W'(FFT_RST_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(FRAME_TIMEOUT - 1);
    localparam logic [RTY_W-1:0] RTY_LAST = RTY_W'(MAX_RETRY - 1);

    logic [2:0]              state_q, state_d;
    logic [RST_W-1:0]        rst_cnt_q, rst_cnt_d;
    logic [TMR_W-1:0]        timer_q, timer_d;
    logic [RTY_W-1:0]        retry_q, retry_d;
    logic                    from_run_q, from_run_d;
    logic [FFT_CONF_WID-1:0] tdata_q, tdata_d;
    logic                    tvalid_q, tvalid_d;
    logic                    aresetn_q, aresetn_d;
    logic                    ospfb_en_q, ospfb_en_d;
    logic                    fault_q, fault_d;

    always_comb begin
        state_d    = state_q;
        rst_cnt_d  = rst_cnt_q;
        timer_d    = timer_q;
        retry_d    = retry_q;
        from_run_d = from_run_q;
        tdata_d    = tdata_q;

        if (!en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: state_d = FFT_RST;
                FFT_RST: begin
                    if (rst_cnt_q == RST_LAST) state_d = CONFIG;
                    else                       rst_cnt_d = rst_cnt_q + 1'b1;
                end
                // Only en=0 may abort a pending handshake.
                CONFIG: begin
                    if (tvalid_q && m_axis_fft_config_tready) begin
                        state_d = from_run_q ? RUN : WAIT_FRAME;
                    end
                end
                WAIT_FRAME: begin
                    if (timer_q == TMR_LAST)       state_d = RESYNC;
                    else if (event_frame_started)  state_d = RUN;
                    else                           timer_d = timer_q + 1'b1;
                end
                RUN: begin
                    if (event_tlast_unexpected || event_tlast_missing) state_d = RESYNC;
                    else if (cfg_update)                               state_d = CONFIG;
                end
                RESYNC: begin
                    if (retry_q == RTY_LAST) begin
                        state_d = FAULT;
                    end else begin
                        retry_d = retry_q + 1'b1;
                        state_d = FFT_RST;
                    end
                end
                FAULT:   state_d = FAULT;
                default: state_d = IDLE;
            endcase
        end

        // State-entry actions.
        if (state_d == FFT_RST && state_q != FFT_RST) rst_cnt_d = '0;
        if (state_d == WAIT_FRAME && state_q != WAIT_FRAME) timer_d = '0;
        if (state_d == CONFIG && state_q != CONFIG) begin
            tdata_d    = {cfg_sched, cfg_fwd};
            from_run_d = (state_q == RUN);
        end
        if (state_d == IDLE) retry_d = '0;

        // Outputs are registered copies of what the next state implies.
        tvalid_d   = (state_d == CONFIG);
        aresetn_d  = (state_d == CONFIG) || (state_d == WAIT_FRAME) || (state_d == RUN);
        ospfb_en_d = (state_d == WAIT_FRAME) || (state_d == RUN) ||
                     (state_d == CONFIG && from_run_d);
        fault_d    = (state_d == FAULT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rst_cnt_q  <= '0;
            timer_q    <= '0;
            retry_q    <= '0;
            from_run_q <= 1'b0;
            tdata_q    <= '0;
            tvalid_q   <= 1'b0;
            aresetn_q  <= 1'b0;
            ospfb_en_q <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rst_cnt_q  <= rst_cnt_d;
            timer_q    <= timer_d;
            retry_q    <= retry_d;
            from_run_q <= from_run_d;
            tdata_q    <= tdata_d;
            tvalid_q   <= tvalid_d;
            aresetn_q  <= aresetn_d;
            ospfb_en_q <= ospfb_en_d;
            fault_q    <= fault_d;
        end
    end

    assign state                    = state_q;
    assign m_axis_fft_config_tdata  = tdata_q;
    assign m_axis_fft_config_tvalid = tvalid_q;
    assign fft_aresetn              = aresetn_q;
    assign ospfb_en                 = ospfb_en_q;
    assign fault                    = fault_q;

`ifdef OSPFB_FFT_SEQ_STATS_EN
    localparam logic [CNT_WID-1:0] CNT_MAX = '1;

    logic [CNT_WID-1:0] overflow_cnt_q, halt_cnt_q, resync_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_cnt_q <= '0;
            halt_cnt_q     <= '0;
            resync_cnt_q   <= '0;
        end else begin
            if (state_q == RUN && event_fft_overflow && overflow_cnt_q != CNT_MAX) begin
                overflow_cnt_q <= overflow_cnt_q + 1'b1;
            end
            if (state_q == RUN && event_data_in_channel_halt && halt_cnt_q != CNT_MAX) begin
                halt_cnt_q <= halt_cnt_q + 1'b1;
            end
            if (state_q == RESYNC && resync_cnt_q != CNT_MAX) begin
                resync_cnt_q <= resync_cnt_q + 1'b1;
            end
        end
    end

    assign overflow_cnt = overflow_cnt_q;
    assign halt_cnt     = halt_cnt_q;
    assign resync_cnt   = resync_cnt_q;
`else
    logic unused_stats;
    assign unused_stats = event_fft_overflow ^ event_data_in_channel_halt;

    assign overflow_cnt = '0;
    assign halt_cnt     = '0;
    assign resync_cnt   = '0;
`endif

endmodule

// File: tb/tb_ospfb_fft_sequencer.sv
// Directed, randomised bench for ospfb_fft_sequencer; expectations come from the behavioural rules.
module tb_ospfb_fft_sequencer;

    localparam int unsigned CONF_WID = 16;
    localparam int unsigned TIMEOUT  = 4096;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RST    = 3'd1;
    localparam logic [2:0] S_CFG    = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_RUN    = 3'd4;
    localparam logic [2:0] S_RESYNC = 3'd5;
    localparam logic [2:0] S_FAULT  = 3'd6;

`ifdef OSPFB_FFT_SEQ_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic                en;
    logic [CONF_WID-2:0] cfg_sched;
    logic                cfg_fwd;
    logic                cfg_update;
    logic [CONF_WID-1:0] m_axis_fft_config_tdata;
    logic                m_axis_fft_config_tvalid;
    logic                m_axis_fft_config_tready;
    logic                fft_aresetn;
    logic                ospfb_en;
    logic                event_frame_started;
    logic                event_tlast_unexpected;
    logic                event_tlast_missing;
    logic                event_fft_overflow;
    logic                event_data_in_channel_halt;
    logic [2:0]          state;
    logic                fault;
    logic [15:0]         overflow_cnt;
    logic [15:0]         halt_cnt;
    logic [15:0]         resync_cnt;

    ospfb_fft_sequencer dut (
        .clk                        (clk),
        .rst                        (rst),
        .en                         (en),
        .cfg_sched                  (cfg_sched),
        .cfg_fwd                    (cfg_fwd),
        .cfg_update                 (cfg_update),
        .m_axis_fft_config_tdata    (m_axis_fft_config_tdata),
        .m_axis_fft_config_tvalid   (m_axis_fft_config_tvalid),
        .m_axis_fft_config_tready   (m_axis_fft_config_tready),
        .fft_aresetn                (fft_aresetn),
        .ospfb_en                   (ospfb_en),
        .event_frame_started        (event_frame_started),
        .event_tlast_unexpected     (event_tlast_unexpected),
        .event_tlast_missing        (event_tlast_missing),
        .event_fft_overflow         (event_fft_overflow),
        .event_data_in_channel_halt (event_data_in_channel_halt),
        .state                      (state),
        .fault                      (fault),
        .overflow_cnt               (overflow_cnt),
        .halt_cnt                   (halt_cnt),
        .resync_cnt                 (resync_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int exp_ovf = 0;
    int exp_halt = 0;
    int exp_rsync = 0;

    // Expected statistic value: live count when stats are built, otherwise tied to zero.
    function automatic logic [31:0] stat(input int n);
        return STATS ? 32'(n) : 32'd0;
    endfunction

    function automatic logic [31:0] cfg_word(input logic [CONF_WID-2:0] s, input logic f);
        return 32'({s, f});
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] target, input int budget, input string tag);
        int n = 0;
        while (state !== target && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(state), 32'(target));
    endtask

    task automatic reach_run(input string tag);
        m_axis_fft_config_tready = 1'b1;
        wait_state(S_WAIT, 20, {tag, "_wait"});
        event_frame_started = 1'b1;
        tick();
        event_frame_started = 1'b0;
        check({tag, "_run"}, 32'(state), 32'(S_RUN));
    endtask

    initial begin
        logic [CONF_WID-2:0] s2;
        logic                f2;
        logic [31:0]         held;
        int                  wait_cycles;
        bit                  en_held;

        rst = 1'b1;
        en = 1'b0;
        cfg_sched = '0;
        cfg_fwd = 1'b0;
        cfg_update = 1'b0;
        m_axis_fft_config_tready = 1'b0;
        event_frame_started = 1'b0;
        event_tlast_unexpected = 1'b0;
        event_tlast_missing = 1'b0;
        event_fft_overflow = 1'b0;
        event_data_in_channel_halt = 1'b0;

        tick();
        tick();
        check("rst_state", 32'(state), 32'(S_IDLE));
        check("rst_aresetn", 32'(fft_aresetn), 32'd0);
        check("rst_tvalid", 32'(m_axis_fft_config_tvalid), 32'd0);
        check("rst_tdata", 32'(m_axis_fft_config_tdata), 32'd0);
        check("rst_ospfb_en", 32'(ospfb_en), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_resync_cnt", 32'(resync_cnt), 32'd0);
        rst = 1'b0;
        tick();

        // 1: bring-up with a fixed schedule
        cfg_sched = 15'h2AAA;
        cfg_fwd = 1'b1;
        m_axis_fft_config_tready = 1'b1;
        en = 1'b1;
        tick();
        check("t1_rst0_state", 32'(state), 32'(S_RST));
        check("t1_rst0_aresetn", 32'(fft_aresetn), 32'd0);
        tick();
        check("t1_rst1_state", 32'(state), 32'(S_RST));
        check("t1_rst1_aresetn", 32'(fft_aresetn), 32'd0);
        tick();
        check("t1_cfg_state", 32'(state), 32'(S_CFG));
        check("t1_cfg_aresetn", 32'(fft_aresetn), 32'd1);
        check("t1_cfg_tvalid", 32'(m_axis_fft_config_tvalid), 32'd1);
        check("t1_cfg_tdata", 32'(m_axis_fft_config_tdata), 32'h5555);
        tick();
        check("t1_wait_state", 32'(state), 32'(S_WAIT));
        check("t1_wait_tvalid", 32'(m_axis_fft_config_tvalid), 32'd0);
        check("t1_wait_ospfb_en", 32'(ospfb_en), 32'd1);
        event_frame_started = 1'b1;
        tick();
        event_frame_started = 1'b0;
        check("t1_run_state", 32'(state), 32'(S_RUN));
        check("t1_run_ospfb_en", 32'(ospfb_en), 32'd1);

        // 2: reconfig from RUN with a stalled config channel
        m_axis_fft_config_tready = 1'b0;
        s2 = 15'($urandom);
        f2 = 1'($urandom);
        cfg_sched = s2;
        cfg_fwd = f2;
        held = cfg_word(s2, f2);
        cfg_update = 1'b1;
        tick();
        cfg_update = 1'b0;
        check("t2_cfg_state", 32'(state), 32'(S_CFG));
        check("t2_cfg_ospfb_en", 32'(ospfb_en), 32'd1);
        for (int i = 0; i < 10; i++) begin
            cfg_sched = 15'($urandom);
            cfg_fwd = 1'($urandom);
            tick();
            check("t2_hold_tvalid", 32'(m_axis_fft_config_tvalid), 32'd1);
            check("t2_hold_tdata", 32'(m_axis_fft_config_tdata), held);
            check("t2_hold_state", 32'(state), 32'(S_CFG));
        end
        m_axis_fft_config_tready = 1'b1;
        tick();
        check("t2_back_run", 32'(state), 32'(S_RUN));
        check("t2_back_tvalid", 32'(m_axis_fft_config_tvalid), 32'd0);
        check("t2_back_ospfb_en", 32'(ospfb_en), 32'd1);

        // 5: counted non-fatal events, then tlast error beats cfg_update
        for (int i = 0; i < 5; i++) begin
            event_fft_overflow = 1'b1;
            event_data_in_channel_halt = 1'($urandom);
            if (event_data_in_channel_halt) exp_halt++;
            exp_ovf++;
            tick();
            event_fft_overflow = 1'b0;
            event_data_in_channel_halt = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
        end
        check("t5_still_run", 32'(state), 32'(S_RUN));
        cfg_update = 1'b1;
        event_tlast_unexpected = 1'b1;
        tick();
        cfg_update = 1'b0;
        event_tlast_unexpected = 1'b0;
        check("t5_resync_state", 32'(state), 32'(S_RESYNC));
        check("t5_resync_ospfb_en", 32'(ospfb_en), 32'd0);
        check("t5_resync_aresetn", 32'(fft_aresetn), 32'd0);
        check("t5_overflow_cnt", 32'(overflow_cnt), stat(exp_ovf));
        check("t5_halt_cnt", 32'(halt_cnt), stat(exp_halt));
        exp_rsync++;
        tick();
        check("t5_retry_rst", 32'(state), 32'(S_RST));
        check("t5_resync_cnt", 32'(resync_cnt), stat(exp_rsync));
        reach_run("t5");

        // en=0 outranks a simultaneous tlast error
        en = 1'b0;
        event_tlast_missing = 1'b1;
        tick();
        event_tlast_missing = 1'b0;
        check("pri_idle_state", 32'(state), 32'(S_IDLE));
        check("pri_idle_ospfb_en", 32'(ospfb_en), 32'd0);
        check("pri_idle_aresetn", 32'(fft_aresetn), 32'd0);
        tick();
        check("pri_resync_cnt", 32'(resync_cnt), stat(exp_rsync));

        // 3: repeated framing errors exhaust the retry budget
        en = 1'b1;
        reach_run("t3_start");
        for (int k = 1; k <= 3; k++) begin
            event_tlast_missing = 1'b1;
            tick();
            event_tlast_missing = 1'b0;
            check("t3_resync_state", 32'(state), 32'(S_RESYNC));
            check("t3_resync_ospfb_en", 32'(ospfb_en), 32'd0);
            exp_rsync++;
            tick();
            check("t3_after_resync", 32'(state), (k == 3) ? 32'(S_FAULT) : 32'(S_RST));
            if (k < 3) reach_run("t3_retry");
        end
        check("t3_fault", 32'(fault), 32'd1);
        check("t3_fault_aresetn", 32'(fft_aresetn), 32'd0);
        check("t3_fault_ospfb_en", 32'(ospfb_en), 32'd0);
        check("t3_resync_cnt", 32'(resync_cnt), stat(exp_rsync));
        repeat (5) tick();
        check("t3_fault_sticky", 32'(state), 32'(S_FAULT));
        en = 1'b0;
        tick();
        check("t3_clear_state", 32'(state), 32'(S_IDLE));
        check("t3_clear_fault", 32'(fault), 32'd0);
        en = 1'b1;
        tick();
        check("t3_restart", 32'(state), 32'(S_RST));

        // 4: no frame ever starts
        m_axis_fft_config_tready = 1'b1;
        wait_state(S_WAIT, 20, "t4_reach_wait");
        wait_cycles = 1;
        en_held = 1'b1;
        while (state === S_WAIT && wait_cycles < TIMEOUT + 100) begin
            if (ospfb_en !== 1'b1) en_held = 1'b0;
            tick();
            if (state === S_WAIT) wait_cycles++;
        end
        check("t4_wait_cycles", 32'(wait_cycles), 32'(TIMEOUT));
        check("t4_en_during_wait", 32'(en_held), 32'd1);
        check("t4_timeout_state", 32'(state), 32'(S_RESYNC));
        check("t4_timeout_ospfb_en", 32'(ospfb_en), 32'd0);
        exp_rsync++;
        tick();
        check("t4_retry_rst", 32'(state), 32'(S_RST));
        check("t4_resync_cnt", 32'(resync_cnt), stat(exp_rsync));

        // 6: asynchronous reset in the middle of a pending handshake
        m_axis_fft_config_tready = 1'b0;
        wait_state(S_CFG, 20, "t6_reach_cfg");
        check("t6_tvalid_pending", 32'(m_axis_fft_config_tvalid), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        check("t6_async_state", 32'(state), 32'(S_IDLE));
        check("t6_async_tvalid", 32'(m_axis_fft_config_tvalid), 32'd0);
        check("t6_async_aresetn", 32'(fft_aresetn), 32'd0);
        check("t6_async_tdata", 32'(m_axis_fft_config_tdata), 32'd0);
        check("t6_async_resync_cnt", 32'(resync_cnt), 32'd0);
        check("t6_async_overflow_cnt", 32'(overflow_cnt), 32'd0);
        tick();
        rst = 1'b0;
        en = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
